// File: rtl/regs_dbg_arbiter_if.sv
//------------------------------------------------------------------------------
// regs_dbg_arbiter_if
// Bundles the EX writeback, JTAG debug handshake and register-file port
// signals that pass through the debug arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface regs_dbg_arbiter_if;
    // EX-stage writeback
    logic        ex_we_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    // JTAG debug access, four-phase req/ack
    logic        jtag_req_i;
    logic        jtag_we_i;
    logic [4:0]  jtag_addr_i;
    logic [31:0] jtag_wdata_i;
    logic        jtag_ack_o;
    logic [31:0] jtag_rdata_o;
    // Pipeline stall request
    logic        stall_o;
    // Register file write port and spare read port
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [4:0]  rf_raddr_o;
    logic [31:0] rf_rdata_i;

    // Arbiter side
    modport slave (
        input  ex_we_i, ex_waddr_i, ex_wdata_i,
        input  jtag_req_i, jtag_we_i, jtag_addr_i, jtag_wdata_i,
        output jtag_ack_o, jtag_rdata_o,
        output stall_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o, rf_raddr_o,
        input  rf_rdata_i
    );

    // Environment side (pipeline, debug module, register file)
    modport master (
        output ex_we_i, ex_waddr_i, ex_wdata_i,
        output jtag_req_i, jtag_we_i, jtag_addr_i, jtag_wdata_i,
        input  jtag_ack_o, jtag_rdata_o,
        input  stall_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o, rf_raddr_o,
        output rf_rdata_i
    );
endinterface

`default_nettype wire

// File: rtl/regs_dbg_arbiter.sv
//------------------------------------------------------------------------------
// regs_dbg_arbiter
// Shares the register-file write port and spare read port between EX
// writeback (always preferred) and JTAG debug accesses. A JTAG request
// starved for STARVE_LIMIT cycles raises stall_o until it is served.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regs_dbg_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,   // asynchronous, active low
    regs_dbg_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        STALL   = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;

    logic             lat_we;
    logic [4:0]       lat_addr;
    logic [31:0]      lat_wdata;

    logic             ack;
    logic             stall;
    logic [31:0]      rdata;

    logic             grant;
    logic             addr_zero;

    // The JTAG access takes the port in any cycle EX leaves it free.
    assign grant     = ((state == PENDING) || (state == STALL)) && !bus.ex_we_i;
    assign addr_zero = (lat_addr == 5'd0);
    assign cnt_inc   = cnt + CNT_W'(1);

    // Next-state and starvation-counter decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.jtag_req_i) begin
                    state_nxt = PENDING;
                    cnt_nxt   = '0;
                end
            end
            PENDING: begin
                if (grant) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == LIMIT) begin
                        state_nxt = STALL;
                    end
                end
            end
            STALL: begin
                if (grant) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                // Holding in RESP while req stays high gives one ack per req.
                if (!bus.jtag_req_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counter and registered ack/stall decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            ack   <= 1'b0;
            stall <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ack   <= (state_nxt == RESP);
            stall <= (state_nxt == STALL);
        end
    end

    // Capture the JTAG command once, when it is first seen in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_we    <= 1'b0;
            lat_addr  <= 5'd0;
            lat_wdata <= 32'd0;
        end else if ((state == IDLE) && bus.jtag_req_i) begin
            lat_we    <= bus.jtag_we_i;
            lat_addr  <= bus.jtag_addr_i;
            lat_wdata <= bus.jtag_wdata_i;
        end
    end

    // Read result is taken in the grant cycle, so writes return the old value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= 32'd0;
        end else if (grant) begin
            rdata <= addr_zero ? 32'd0 : bus.rf_rdata_i;
        end
    end

    // Register-file port: EX passes through except in the grant cycle.
    assign bus.rf_we_o      = grant ? (lat_we && !addr_zero) : bus.ex_we_i;
    assign bus.rf_waddr_o   = grant ? lat_addr  : bus.ex_waddr_i;
    assign bus.rf_wdata_o   = grant ? lat_wdata : bus.ex_wdata_i;
    assign bus.rf_raddr_o   = lat_addr;

    assign bus.jtag_ack_o   = ack;
    assign bus.jtag_rdata_o = rdata;
    assign bus.stall_o      = stall;

endmodule

`default_nettype wire

// File: tb/tb_regs_dbg_arbiter.sv
//------------------------------------------------------------------------------
// tb_regs_dbg_arbiter
// Directed bench for regs_dbg_arbiter with a small register-file model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_regs_dbg_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    regs_dbg_arbiter_if bus ();

    regs_dbg_arbiter #(
        .STARVE_LIMIT (4),
        .CNT_W        (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register-file model; x0 is an ordinary cell here so that the arbiter's
    // own zero handling is what the bench observes.
    logic [31:0] regs [0:31];
    logic        load_en   = 1'b0;
    logic [4:0]  load_addr = 5'd0;
    logic [31:0] load_data = 32'd0;

    assign bus.rf_rdata_i = regs[bus.rf_raddr_o];

    // Model write port, plus a bench-only preload path.
    always @(posedge clk) begin
        if (load_en)
            regs[load_addr] <= load_data;
        else if (bus.rf_we_o)
            regs[bus.rf_waddr_o] <= bus.rf_wdata_o;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load_reg(input logic [4:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en   = 1'b0;
    endtask

    task automatic set_jtag(input logic req, input logic we,
                            input logic [4:0] a, input logic [31:0] d);
        bus.jtag_req_i   = req;
        bus.jtag_we_i    = we;
        bus.jtag_addr_i  = a;
        bus.jtag_wdata_i = d;
    endtask

    task automatic test_reset();
        step();
        step();
        vectors++; if (bus.jtag_ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", bus.jtag_ack_o); end
        vectors++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", bus.stall_o); end
        vectors++; if (bus.jtag_rdata_o !== 32'd0) begin errors++; $display("FAIL rst_rdata: got %h want 0", bus.jtag_rdata_o); end
        vectors++; if (bus.rf_raddr_o !== 5'd0) begin errors++; $display("FAIL rst_raddr: got %0d want 0", bus.rf_raddr_o); end
        vectors++; if (bus.rf_we_o !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", bus.rf_we_o); end
        rst = 1'b1;
        for (int i = 0; i < 32; i++) load_reg(5'(i), 32'd0);
        load_reg(5'd7, 32'h1234_5678);
        load_reg(5'd0, 32'hCAFE_0000);
    endtask

    task automatic test_write();
        bus.ex_we_i = 1'b0;
        set_jtag(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF);
        step();
        vectors++; if (bus.rf_we_o !== 1'b1) begin errors++; $display("FAIL wr_grant_we: got %b want 1", bus.rf_we_o); end
        vectors++; if (bus.rf_waddr_o !== 5'd5) begin errors++; $display("FAIL wr_grant_addr: got %0d want 5", bus.rf_waddr_o); end
        vectors++; if (bus.rf_wdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_grant_data: got %h want deadbeef", bus.rf_wdata_o); end
        vectors++; if (bus.jtag_ack_o !== 1'b0) begin errors++; $display("FAIL wr_early_ack: got %b want 0", bus.jtag_ack_o); end
        step();
        vectors++; if (bus.jtag_ack_o !== 1'b1) begin errors++; $display("FAIL wr_ack: got %b want 1", bus.jtag_ack_o); end
        vectors++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL wr_stall: got %b want 0", bus.stall_o); end
        vectors++; if (regs[5] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_reg5: got %h want deadbeef", regs[5]); end
        bus.jtag_req_i = 1'b0;
        step();
        vectors++; if (bus.jtag_ack_o !== 1'b0) begin errors++; $display("FAIL wr_ack_drop: got %b want 0", bus.jtag_ack_o); end
    endtask

    task automatic test_read();
        set_jtag(1'b1, 1'b0, 5'd7, 32'd0);
        step();
        vectors++; if (bus.rf_we_o !== 1'b0) begin errors++; $display("FAIL rd_grant_we: got %b want 0", bus.rf_we_o); end
        vectors++; if (bus.rf_raddr_o !== 5'd7) begin errors++; $display("FAIL rd_raddr: got %0d want 7", bus.rf_raddr_o); end
        step();
        vectors++; if (bus.jtag_ack_o !== 1'b1) begin errors++; $display("FAIL rd_ack: got %b want 1", bus.jtag_ack_o); end
        vectors++; if (bus.jtag_rdata_o !== 32'h1234_5678) begin errors++; $display("FAIL rd_data: got %h want 12345678", bus.jtag_rdata_o); end
        bus.jtag_req_i = 1'b0;
        step();
    endtask

    task automatic test_starve();
        bus.ex_we_i    = 1'b1;
        bus.ex_waddr_i = 5'd9;
        bus.ex_wdata_i = 32'hA5A5_A5A5;
        set_jtag(1'b1, 1'b1, 5'd3, 32'h0000_0001);
        step();
        vectors++; if (bus.rf_we_o !== 1'b1) begin errors++; $display("FAIL st_ex_we: got %b want 1", bus.rf_we_o); end
        vectors++; if (bus.rf_waddr_o !== 5'd9) begin errors++; $display("FAIL st_ex_addr: got %0d want 9", bus.rf_waddr_o); end
        vectors++; if (bus.rf_wdata_o !== 32'hA5A5_A5A5) begin errors++; $display("FAIL st_ex_data: got %h want a5a5a5a5", bus.rf_wdata_o); end
        for (int i = 1; i <= 3; i++) begin
            step();
            vectors++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL st_early_stall%0d: got %b want 0", i, bus.stall_o); end
        end
        step();
        vectors++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL st_stall_rise: got %b want 1", bus.stall_o); end
        step();
        vectors++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL st_stall_hold: got %b want 1", bus.stall_o); end
        bus.ex_we_i = 1'b0;
        #1;
        vectors++; if (bus.rf_we_o !== 1'b1) begin errors++; $display("FAIL st_grant_we: got %b want 1", bus.rf_we_o); end
        vectors++; if (bus.rf_waddr_o !== 5'd3) begin errors++; $display("FAIL st_grant_addr: got %0d want 3", bus.rf_waddr_o); end
        vectors++; if (bus.rf_wdata_o !== 32'h1) begin errors++; $display("FAIL st_grant_data: got %h want 1", bus.rf_wdata_o); end
        step();
        vectors++; if (bus.jtag_ack_o !== 1'b1) begin errors++; $display("FAIL st_ack: got %b want 1", bus.jtag_ack_o); end
        vectors++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL st_stall_fall: got %b want 0", bus.stall_o); end
        vectors++; if (regs[3] !== 32'h1) begin errors++; $display("FAIL st_reg3: got %h want 1", regs[3]); end
        bus.jtag_req_i = 1'b0;
        step();
    endtask

    task automatic test_addr_zero();
        bus.ex_we_i = 1'b0;
        set_jtag(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
        step();
        vectors++; if (bus.rf_we_o !== 1'b0) begin errors++; $display("FAIL z_grant_we: got %b want 0", bus.rf_we_o); end
        step();
        vectors++; if (bus.jtag_ack_o !== 1'b1) begin errors++; $display("FAIL z_wr_ack: got %b want 1", bus.jtag_ack_o); end
        vectors++; if (regs[0] !== 32'hCAFE_0000) begin errors++; $display("FAIL z_reg0: got %h want cafe0000", regs[0]); end
        bus.jtag_req_i = 1'b0;
        step();
        set_jtag(1'b1, 1'b0, 5'd0, 32'd0);
        step();
        step();
        vectors++; if (bus.jtag_ack_o !== 1'b1) begin errors++; $display("FAIL z_rd_ack: got %b want 1", bus.jtag_ack_o); end
        vectors++; if (bus.jtag_rdata_o !== 32'd0) begin errors++; $display("FAIL z_rd_data: got %h want 0", bus.jtag_rdata_o); end
        bus.jtag_req_i = 1'b0;
        step();
    endtask

    task automatic test_reset_in_stall();
        bus.ex_we_i    = 1'b1;
        bus.ex_waddr_i = 5'd9;
        bus.ex_wdata_i = 32'h0000_0099;
        set_jtag(1'b1, 1'b1, 5'd12, 32'h0000_0077);
        for (int i = 0; i < 5; i++) step();
        vectors++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL rs_in_stall: got %b want 1", bus.stall_o); end
        rst = 1'b0;
        #1;
        vectors++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL rs_stall_drop: got %b want 0", bus.stall_o); end
        vectors++; if (bus.jtag_ack_o !== 1'b0) begin errors++; $display("FAIL rs_ack_drop: got %b want 0", bus.jtag_ack_o); end
        bus.ex_we_i    = 1'b0;
        bus.jtag_req_i = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (bus.rf_we_o !== 1'b0) begin errors++; $display("FAIL rs_post_we%0d: got %b want 0", i, bus.rf_we_o); end
        end
        vectors++; if (regs[12] !== 32'd0) begin errors++; $display("FAIL rs_reg12: got %h want 0", regs[12]); end
        vectors++; if (bus.rf_raddr_o !== 5'd0) begin errors++; $display("FAIL rs_raddr: got %0d want 0", bus.rf_raddr_o); end
        vectors++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL rs_post_stall: got %b want 0", bus.stall_o); end
    endtask

    task automatic test_back_to_back();
        int   we_cnt   = 0;
        int   ack_cnt  = 0;
        logic prev_ack = 1'b0;
        bus.ex_we_i = 1'b0;
        set_jtag(1'b1, 1'b1, 5'd4, 32'h0000_0044);
        step();
        // Grant cycle, ack cycle, then req held high for ten more cycles.
        for (int i = 0; i < 12; i++) begin
            if (bus.rf_we_o && (bus.rf_waddr_o == 5'd4)) we_cnt++;
            if (bus.jtag_ack_o && !prev_ack) ack_cnt++;
            prev_ack = bus.jtag_ack_o;
            if (i == 3) bus.jtag_wdata_i = 32'h0000_0099;
            step();
        end
        vectors++; if (we_cnt !== 1) begin errors++; $display("FAIL bb_writes: got %0d want 1", we_cnt); end
        vectors++; if (ack_cnt !== 1) begin errors++; $display("FAIL bb_acks: got %0d want 1", ack_cnt); end
        vectors++; if (bus.jtag_ack_o !== 1'b1) begin errors++; $display("FAIL bb_ack_held: got %b want 1", bus.jtag_ack_o); end
        vectors++; if (regs[4] !== 32'h44) begin errors++; $display("FAIL bb_reg4_first: got %h want 44", regs[4]); end
        bus.jtag_req_i = 1'b0;
        step();
        vectors++; if (bus.jtag_ack_o !== 1'b0) begin errors++; $display("FAIL bb_ack_low: got %b want 0", bus.jtag_ack_o); end
        set_jtag(1'b1, 1'b1, 5'd4, 32'h0000_0055);
        step();
        vectors++; if (bus.rf_we_o !== 1'b1) begin errors++; $display("FAIL bb_second_we: got %b want 1", bus.rf_we_o); end
        vectors++; if (bus.rf_wdata_o !== 32'h55) begin errors++; $display("FAIL bb_second_data: got %h want 55", bus.rf_wdata_o); end
        step();
        vectors++; if (bus.jtag_ack_o !== 1'b1) begin errors++; $display("FAIL bb_second_ack: got %b want 1", bus.jtag_ack_o); end
        vectors++; if (regs[4] !== 32'h55) begin errors++; $display("FAIL bb_reg4_second: got %h want 55", regs[4]); end
        bus.jtag_req_i = 1'b0;
        step();
    endtask

    initial begin
        bus.ex_we_i    = 1'b0;
        bus.ex_waddr_i = 5'd0;
        bus.ex_wdata_i = 32'd0;
        set_jtag(1'b0, 1'b0, 5'd0, 32'd0);
        test_reset();
        test_write();
        test_read();
        test_starve();
        test_addr_zero();
        test_reset_in_stall();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
